dut_rr_arbiter: RTL

- Round-robin arbiter that shares the single valid/data/ready input channel of the handshake DUT among NUM_REQ requesters.
- Latches the winning requester's byte and drives a one-cycle valid pulse to the DUT. It then waits for the DUT's registered ready, acknowledges the winner and rotates priority.
- A watchdog aborts any transfer whose ready never arrives.
- Sits between stimulus sources (agents or upstream blocks) and the DUT.

---
 rtl/dut_rr_arbiter.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/dut_rr_arbiter.sv
// -----------------------------------------------------------------------------
// dut_rr_arbiter
//
// Round-robin arbiter sharing one valid/data/ready channel among NUM_REQ
// requesters. The winner's payload is latched at grant, presented to the
// downstream block with a single-cycle valid pulse, and the transfer then
// waits for ready. A completed transfer acks the winner; a transfer whose
// ready never arrives within TIMEOUT wait cycles is aborted with a
// timeout_err pulse. In both cases priority rotates past the granted index.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous reset, active low
//   req_valid    per-requester request, held until its req_ack
//   req_data     requester i payload at [i*DATA_W +: DATA_W]
//   req_ack      one-cycle completion pulse to the granted requester
//   dut_valid    single-cycle valid to the downstream block
//   dut_data     latched payload (holds while dut_valid is low)
//   dut_ready    ready from the downstream block (only honoured in WAIT)
//   busy         high while a transfer is in SEND or WAIT
//   grant_id     index of the current or most recent grant
//   timeout_err  one-cycle pulse when a transfer is aborted
//   xfer_count   completed transfers, saturating at 16'hFFFF
//
// State | meaning
// IDLE  | no transfer; pick the next eligible requester from the pointer
// SEND  | dut_valid high for exactly this cycle
// WAIT  | waiting for dut_ready; watchdog counts idle wait cycles
// -----------------------------------------------------------------------------
module dut_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic                       dut_valid,
  output logic [DATA_W-1:0]          dut_data,
  input  logic                       dut_ready,
  output logic                       busy,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_err,
  output logic [15:0]                xfer_count
);

  localparam int         ID_W    = $clog2(NUM_REQ);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [7:0]          cnt_q, cnt_d;

  logic [NUM_REQ-1:0]  req_ack_d;
  logic                dut_valid_d;
  logic [DATA_W-1:0]   dut_data_d;
  logic                busy_d;
  logic [ID_W-1:0]     grant_id_d;
  logic                timeout_err_d;
  logic [15:0]         xfer_count_d;

  logic [NUM_REQ-1:0]  elig;
  logic                found;
  logic [ID_W-1:0]     win_id;
  logic [ID_W-1:0]     scan_id;
  logic [ID_W-1:0]     ptr_after_grant;

  // (base + off) mod NUM_REQ without a divider; off is always < NUM_REQ.
  function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return ID_W'(s);
  endfunction

  // A requester sitting in its ack cycle still shows req_valid high; mask it
  // so the same request is not granted a second time.
  assign elig = req_valid & ~req_ack;

  always_comb begin : pick_winner
    found   = 1'b0;
    win_id  = '0;
    scan_id = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_id = wrap_add(ptr_q, k);
      if (!found && elig[scan_id]) begin
        found  = 1'b1;
        win_id = scan_id;
      end
    end
  end

  assign ptr_after_grant = wrap_add(grant_id, 1);

  always_comb begin : fsm_next
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    req_ack_d     = '0;
    dut_valid_d   = 1'b0;
    dut_data_d    = dut_data;
    busy_d        = busy;
    grant_id_d    = grant_id;
    timeout_err_d = 1'b0;
    xfer_count_d  = xfer_count;

    case (state_q)
      IDLE: begin
        if (found) begin
          dut_data_d  = req_data[win_id*DATA_W +: DATA_W];
          grant_id_d  = win_id;
          dut_valid_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = SEND;
        end
      end

      SEND: begin
        cnt_d   = '0;
        state_d = WAIT;
      end

      WAIT: begin
        if (dut_ready) begin
          req_ack_d    = NUM_REQ'(1) << grant_id;
          xfer_count_d = (xfer_count == 16'hFFFF) ? xfer_count
                                                  : xfer_count + 16'd1;
          ptr_d        = ptr_after_grant;
          busy_d       = 1'b0;
          state_d      = IDLE;
        end else if (cnt_q == TO_LAST) begin
          // This cycle is the TIMEOUT-th wait cycle without ready.
          timeout_err_d = 1'b1;
          ptr_d         = ptr_after_grant;
          busy_d        = 1'b0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      req_ack     <= '0;
      dut_valid   <= 1'b0;
      dut_data    <= '0;
      busy        <= 1'b0;
      grant_id    <= '0;
      timeout_err <= 1'b0;
      xfer_count  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      req_ack     <= req_ack_d;
      dut_valid   <= dut_valid_d;
      dut_data    <= dut_data_d;
      busy        <= busy_d;
      grant_id    <= grant_id_d;
      timeout_err <= timeout_err_d;
      xfer_count  <= xfer_count_d;
    end
  end

endmodule
